// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM arbitration slice.
//   ArbState      : arbiter FSM encoding.
//   SDRAM_*_W     : widths of the controller's address, data and byte-mask ports.
package sdram_pkg;

  localparam int SDRAM_ADDR_W = 25;
  localparam int SDRAM_DATA_W = 32;
  localparam int SDRAM_MASK_W = 4;

  typedef enum logic [2:0] {
    WAIT_INIT = 3'd0,
    IDLE      = 3'd1,
    ISSUE     = 3'd2,
    WAIT_DONE = 3'd3,
    RELEASE   = 3'd4
  } ArbState;

endpackage

// File: rtl/sdram_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority encoder.
// Ports:
//   req         in  NUM_REQ : request vector, bit i = requester i.
//   last_grant  in  IDX_W   : index granted most recently.
//   grant_valid out 1       : at least one request is pending.
//   grant_idx   out IDX_W   : first requester found scanning upward from
//                             last_grant+1 with wrap (0 when grant_valid=0).
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx
);

  int   cand;
  logic hit;

  // Scan from the farthest candidate (last_grant itself) back towards the
  // nearest one (last_grant+1), so the nearest pending requester is the last
  // to write the result and therefore wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    hit         = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = (int'(last_grant) + i) % NUM_REQ;
      hit  = 1'b0;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (cand == j) hit = req[j];
      end
      if (hit) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin arbiter sharing one SDRAM controller between
// NUM_REQ (2..4) bus masters, with a per-access timeout watchdog.
// Ports:
//   clk, resetn            : clock; synchronous active-low reset.
//   req_valid  in  NUM_REQ : level request, held until req_ready is seen.
//   req_addr   in  NUM_REQ*25, req_din in NUM_REQ*32, req_wmask in NUM_REQ*4:
//                            packed per-requester access (wmask 0 = read).
//   req_ready  out NUM_REQ : one-cycle completion pulse to the owner.
//   req_err    out 1       : high with req_ready when the access was aborted.
//   req_rdata  out 32      : read data, valid while req_ready is high.
//   mem_addr/mem_din/mem_wmask out : access presented to the controller.
//   mem_valid  out 1       : one-cycle issue pulse.
//   mem_dout   in  32, mem_ready in 1, mem_initialized in 1 : controller side.
//
// Handshake: a requester raises req_valid with its access and holds it until
// it sees its req_ready bit high; that single-cycle pulse ends the access and
// the requester may drop req_valid at the edge that ends the pulse. Towards the
// controller, mem_valid is a single-cycle pulse per grant (the controller keeps
// a sticky copy, so it must never repeat), and mem_ready is a single-cycle
// completion pulse that only counts while an access is outstanding.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*SDRAM_ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*SDRAM_DATA_W-1:0]  req_din,
  input  logic [NUM_REQ*SDRAM_MASK_W-1:0]  req_wmask,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             req_err,
  output logic [SDRAM_DATA_W-1:0]          req_rdata,
  output logic [SDRAM_ADDR_W-1:0]          mem_addr,
  output logic [SDRAM_DATA_W-1:0]          mem_din,
  output logic [SDRAM_MASK_W-1:0]          mem_wmask,
  output logic                             mem_valid,
  input  logic [SDRAM_DATA_W-1:0]          mem_dout,
  input  logic                             mem_ready,
  input  logic                             mem_initialized
);

  localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // The counter is cleared in ISSUE and bumped once per WAIT_DONE cycle, so
  // it holds TIMEOUT_CYCLES-1 during the TIMEOUT_CYCLES-th WAIT_DONE cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

  ArbState                 state_q, state_d;
  logic [IDX_W-1:0]        last_grant_q, last_grant_d;
  logic [IDX_W-1:0]        grant_q, grant_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_REQ-1:0]      grant_onehot;

  logic [NUM_REQ-1:0]      req_ready_d;
  logic                    req_err_d;
  logic [SDRAM_DATA_W-1:0] req_rdata_d;
  logic [SDRAM_ADDR_W-1:0] mem_addr_d;
  logic [SDRAM_DATA_W-1:0] mem_din_d;
  logic [SDRAM_MASK_W-1:0] mem_wmask_d;
  logic                    mem_valid_d;

  logic                    pick_valid;
  logic [IDX_W-1:0]        pick_idx;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req         (req_valid),
    .last_grant  (last_grant_q),
    .grant_valid (pick_valid),
    .grant_idx   (pick_idx)
  );

  assign grant_onehot = NUM_REQ'(1) << grant_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= WAIT_INIT;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      grant_q      <= '0;
      cnt_q        <= '0;
      req_ready    <= '0;
      req_err      <= 1'b0;
      req_rdata    <= '0;
      mem_addr     <= '0;
      mem_din      <= '0;
      mem_wmask    <= '0;
      mem_valid    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      req_ready    <= req_ready_d;
      req_err      <= req_err_d;
      req_rdata    <= req_rdata_d;
      mem_addr     <= mem_addr_d;
      mem_din      <= mem_din_d;
      mem_wmask    <= mem_wmask_d;
      mem_valid    <= mem_valid_d;
    end
  end

  // Next-state and next-output logic. Every output is registered, so each
  // value computed here appears one cycle later: mem_valid set on leaving IDLE
  // is high throughout ISSUE, and req_ready set on leaving WAIT_DONE/ISSUE is
  // high throughout RELEASE.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    req_ready_d  = '0;
    req_err_d    = 1'b0;
    req_rdata_d  = req_rdata;
    mem_addr_d   = mem_addr;
    mem_din_d    = mem_din;
    mem_wmask_d  = mem_wmask;
    mem_valid_d  = 1'b0;

    case (state_q)
      // The controller drives ready high before init completes, so
      // mem_ready carries no meaning here.
      WAIT_INIT: begin
        if (mem_initialized) state_d = IDLE;
      end

      IDLE: begin
        if (!mem_initialized) begin
          state_d = WAIT_INIT;
        end else if (pick_valid) begin
          grant_d      = pick_idx;
          last_grant_d = pick_idx;
          mem_addr_d   = req_addr[pick_idx*SDRAM_ADDR_W +: SDRAM_ADDR_W];
          mem_din_d    = req_din[pick_idx*SDRAM_DATA_W +: SDRAM_DATA_W];
          mem_wmask_d  = req_wmask[pick_idx*SDRAM_MASK_W +: SDRAM_MASK_W];
          mem_valid_d  = 1'b1;
          state_d      = ISSUE;
        end
      end

      // mem_valid is high in this cycle; any mem_ready seen now belongs to
      // nothing we issued and is dropped.
      ISSUE: begin
        cnt_d = '0;
        if (!mem_initialized) begin
          req_ready_d = grant_onehot;
          req_err_d   = 1'b1;
          state_d     = RELEASE;
        end else begin
          state_d = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        if (!mem_initialized) begin
          req_ready_d = grant_onehot;
          req_err_d   = 1'b1;
          state_d     = RELEASE;
        end else if (mem_ready) begin
          req_ready_d = grant_onehot;
          req_rdata_d = mem_dout;
          state_d     = RELEASE;
        end else if (cnt_q >= CNT_LAST) begin
          req_ready_d = grant_onehot;
          req_err_d   = 1'b1;
          state_d     = RELEASE;
        end
      end

      // Completion pulse is visible this cycle; the defaults clear it.
      RELEASE: begin
        state_d = mem_initialized ? IDLE : WAIT_INIT;
      end

      default: begin
        state_d = WAIT_INIT;
      end
    endcase
  end

endmodule
